// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one registered ALU.
// Latency: grant N, alu_enable N+1, response from N+3 (bad op code: from N+1).
// Backpressure: one op in flight; req_ready low until the response is taken.
module alu_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [3:0]           req_op0,
  input  logic [3:0]           req_op1,
  input  logic [WORD_SIZE-1:0] req_a0,
  input  logic [WORD_SIZE-1:0] req_a1,
  input  logic [WORD_SIZE-1:0] req_b0,
  input  logic [WORD_SIZE-1:0] req_b1,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_err,
  output logic [3:0]           alu_op,
  output logic [WORD_SIZE-1:0] alu_in1,
  output logic [WORD_SIZE-1:0] alu_in2,
  output logic                 alu_enable,
  input  logic [WORD_SIZE-1:0] alu_out,
  output logic                 busy
);

  // Op codes understood by the attached ALU; anything else is rejected.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic                   r_last_grant;  // index of the most recent winner
  logic                   r_idx;         // requester owning the op in flight
  logic                   r_err;         // op in flight had an invalid code
  logic [WORD_SIZE-1:0]   r_result;
  logic [3:0]             r_alu_op;
  logic [WORD_SIZE-1:0]   r_alu_in1;
  logic [WORD_SIZE-1:0]   r_alu_in2;

  logic                   w_grant;
  logic                   w_grant_idx;
  logic [3:0]             w_sel_op;
  logic [WORD_SIZE-1:0]   w_sel_a;
  logic [WORD_SIZE-1:0]   w_sel_b;
  logic                   w_op_valid;

  // Round-robin pick: on a tie the requester that did not win last time goes;
  // a lone requester wins regardless of history. Reset masks any grant.
  always_comb begin
    w_grant_idx = req_valid[1];
    if (req_valid == 2'b11) begin
      w_grant_idx = ~r_last_grant;
    end
    w_grant    = (r_state == S_IDLE) && !rst && (req_valid != 2'b00);
    w_sel_op   = w_grant_idx ? req_op1 : req_op0;
    w_sel_a    = w_grant_idx ? req_a1  : req_a0;
    w_sel_b    = w_grant_idx ? req_b1  : req_b0;
    w_op_valid = (w_sel_op == ALU_ADD) || (w_sel_op == ALU_SUB) ||
                 (w_sel_op == ALU_MUL);
  end

  // Next-state and output decode; outputs are a pure function of state so
  // the response bus reads zero whenever no response is being offered.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 2'b00;
    resp_valid   = 2'b00;
    resp_data    = '0;
    resp_err     = 1'b0;
    alu_enable   = 1'b0;
    busy         = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          req_ready    = w_grant_idx ? 2'b10 : 2'b01;
          // A bad op code skips the ALU and answers with an error straight away.
          w_next_state = w_op_valid ? S_ISSUE : S_RESP;
        end
      end
      S_ISSUE: begin
        alu_enable   = 1'b1;
        w_next_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_next_state = S_RESP;
      end
      S_RESP: begin
        resp_valid = r_idx ? 2'b10 : 2'b01;
        resp_data  = r_result;
        resp_err   = r_err;
        // Only the owner's ready bit completes the response.
        if (resp_ready[r_idx]) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons whatever is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Grant bookkeeping, ALU operand registers and result capture.
  // The ALU operand registers only load on a valid grant, so they keep their
  // previous values everywhere outside ISSUE, including across error responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_idx        <= 1'b0;
      r_err        <= 1'b0;
      r_result     <= '0;
      r_alu_op     <= 4'd0;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
    end else begin
      if (w_grant) begin
        r_last_grant <= w_grant_idx;
        r_idx        <= w_grant_idx;
        r_err        <= ~w_op_valid;
        r_result     <= '0;
        if (w_op_valid) begin
          r_alu_op  <= w_sel_op;
          r_alu_in1 <= w_sel_a;
          r_alu_in2 <= w_sel_b;
        end
      end
      if (r_state == S_CAPTURE) begin
        r_result <= alu_out;
      end
    end
  end

  assign alu_op  = r_alu_op;
  assign alu_in1 = r_alu_in1;
  assign alu_in2 = r_alu_in2;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, reset corner sequences and
// randomized transactions against a transaction-level reference model.
module tb_alu_arbiter;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [15:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic [3:0]  alu_op;
  logic [15:0] alu_in1, alu_in2;
  logic        alu_enable;
  logic [15:0] alu_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Expected reference state, kept at transaction level.
  logic        model_last;
  logic [3:0]  exp_op;
  logic [15:0] exp_in1, exp_in2;

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  o0;
    logic [15:0] a0, b0;
    logic [3:0]  o1;
    logic [15:0] a1, b1;
    int          hold;
    logic        w;
    logic [15:0] d;
    logic        e;
  } vec_t;

  alu_arbiter #(.WORD_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1),
    .req_b0(req_b0), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_enable(alu_enable), .alu_out(alu_out), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

  // Arithmetic reference: results are the low 16 bits, computed modulo 2^16.
  function automatic logic [15:0] model_result(input logic [3:0] op,
                                               input logic [15:0] a,
                                               input logic [15:0] b);
    int unsigned ua, ub, r;
    ua = 32'(a);
    ub = 32'(b);
    case (op)
      ALU_ADD: r = (ua + ub) % 65536;
      ALU_SUB: r = (ua + 65536 - ub) % 65536;
      ALU_MUL: r = (ua * ub) % 65536;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  function automatic logic model_pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  // Stand-in ALU: registers its result on the enable edge.
  always @(posedge clk) begin
    if (rst) alu_out <= 16'h0000;
    else if (alu_enable) alu_out <= model_result(alu_op, alu_in1, alu_in2);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_data"}, resp_data, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_alu_op"}, alu_op, 0);
    check({tag, "_alu_in1"}, alu_in1, 0);
    check({tag, "_alu_in2"}, alu_in2, 0);
    check({tag, "_alu_enable"}, alu_enable, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // One full transaction; entered and left just after a rising edge.
  task automatic txn(input vec_t t, output int waited);
    logic [1:0]  g;
    logic [3:0]  op;
    logic [15:0] a, b;
    g  = t.w ? 2'b10 : 2'b01;
    op = t.w ? t.o1 : t.o0;
    a  = t.w ? t.a1 : t.a0;
    b  = t.w ? t.b1 : t.b0;
    req_valid = t.v;
    req_op0 = t.o0; req_a0 = t.a0; req_b0 = t.b0;
    req_op1 = t.o1; req_a1 = t.a1; req_b1 = t.b1;
    resp_ready = 2'b00;
    waited = 0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_resp_valid", resp_valid, 0);
    check("idle_resp_data", resp_data, 0);
    while (req_ready == 2'b00 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
      @(negedge clk);
    end
    check("grant", req_ready, g);
    check("grant_alu_enable", alu_enable, 0);
    if (req_ready !== g) return;
    if (!t.e) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("issue_enable", alu_enable, 1);
      check("issue_op", alu_op, op);
      check("issue_in1", alu_in1, a);
      check("issue_in2", alu_in2, b);
      check("issue_req_ready", req_ready, 0);
      check("issue_resp_valid", resp_valid, 0);
      exp_op = op; exp_in1 = a; exp_in2 = b;
      @(posedge clk); #1;
      @(negedge clk);
      check("capture_enable", alu_enable, 0);
      check("capture_hold_op", alu_op, exp_op);
      check("capture_resp_valid", resp_valid, 0);
    end
    @(posedge clk); #1;
    resp_ready = (t.hold > 0) ? ~g : g;
    @(negedge clk);
    check("resp_valid", resp_valid, g);
    check("resp_data", resp_data, t.d);
    check("resp_err", resp_err, t.e);
    check("resp_alu_enable", alu_enable, 0);
    check("resp_hold_op", alu_op, exp_op);
    check("resp_hold_in1", alu_in1, exp_in1);
    check("resp_hold_in2", alu_in2, exp_in2);
    for (int i = 1; i <= t.hold; i++) begin
      @(posedge clk); #1;
      resp_ready = (i == t.hold) ? g : ~g;
      @(negedge clk);
      check("stall_resp_valid", resp_valid, g);
      check("stall_resp_data", resp_data, t.d);
      check("stall_resp_err", resp_err, t.e);
      check("stall_req_ready", req_ready, 0);
      check("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    resp_ready = 2'b00;
    req_valid  = t.v & ~g;
  endtask

  function automatic logic [3:0] pick_op();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r < 2) return ALU_ADD;
    if (r < 4) return ALU_SUB;
    if (r < 6) return ALU_MUL;
    return 4'($urandom_range(3, 15));
  endfunction

  function automatic logic [15:0] pick_word();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 16'h0000;
    if (r == 1) return 16'hFFFF;
    return 16'($urandom_range(0, 65535));
  endfunction

  vec_t tbl[9];
  vec_t t;
  int   waited;

  initial begin
    // Directed vectors, expected values derived by hand; entered with last_grant=1.
    tbl[0] = '{2'b01, ALU_ADD, 16'd5, 16'd7, ALU_ADD, 16'd0, 16'd0, 0, 1'b0, 16'd12, 1'b0};
    tbl[1] = '{2'b10, ALU_ADD, 16'd0, 16'd0, 4'hF, 16'd9, 16'd9, 0, 1'b1, 16'd0, 1'b1};
    tbl[2] = '{2'b01, ALU_SUB, 16'd0, 16'd1, ALU_ADD, 16'd0, 16'd0, 5, 1'b0, 16'hFFFF, 1'b0};
    tbl[3] = '{2'b11, ALU_ADD, 16'd1, 16'd1, ALU_ADD, 16'd2, 16'd3, 0, 1'b1, 16'd5, 1'b0};
    tbl[4] = '{2'b11, ALU_MUL, 16'h00FF, 16'h0101, ALU_SUB, 16'd9, 16'd9, 1, 1'b0, 16'hFFFF, 1'b0};
    tbl[5] = '{2'b11, ALU_ADD, 16'd1, 16'd1, ALU_ADD, 16'hFFFF, 16'd2, 0, 1'b1, 16'h0001, 1'b0};
    tbl[6] = '{2'b10, ALU_ADD, 16'd0, 16'd0, 4'd3, 16'd4, 16'd4, 2, 1'b1, 16'd0, 1'b1};
    tbl[7] = '{2'b10, ALU_ADD, 16'd0, 16'd0, ALU_MUL, 16'h1234, 16'h0010, 0, 1'b1, 16'h2340, 1'b0};
    tbl[8] = '{2'b11, 4'h8, 16'd1, 16'd1, ALU_ADD, 16'd1, 16'd1, 0, 1'b0, 16'd0, 1'b1};

    // Reset with requests pending: nothing may be granted, all outputs low.
    rst = 1'b1;
    req_valid = 2'b11; resp_ready = 2'b11;
    req_op0 = ALU_ADD; req_a0 = 16'd1; req_b0 = 16'd1;
    req_op1 = ALU_ADD; req_a1 = 16'd1; req_b1 = 16'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00; resp_ready = 2'b00;
    model_last = 1'b1;
    exp_op = 4'd0; exp_in1 = 16'd0; exp_in2 = 16'd0;

    // Tie right after reset: requester 0 first, requester 1 straight after.
    t = '{2'b11, ALU_SUB, 16'd3, 16'd5, ALU_MUL, 16'h0100, 16'h0100, 0, 1'b0, 16'hFFFE, 1'b0};
    txn(t, waited);
    t = '{2'b10, ALU_SUB, 16'd3, 16'd5, ALU_MUL, 16'h0100, 16'h0100, 0, 1'b1, 16'h0000, 1'b0};
    txn(t, waited);
    check("rr_grant_after_handshake", waited, 0);
    model_last = 1'b1;

    for (int i = 0; i < 9; i++) begin
      txn(tbl[i], waited);
      check("table_grant_latency", waited, 0);
      model_last = tbl[i].w;
    end

    // Reset asserted while the op sits in ISSUE: it must vanish silently.
    req_valid = 2'b10; req_op1 = ALU_ADD; req_a1 = 16'd3; req_b1 = 16'd4;
    @(negedge clk);
    check("rst_seq_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 2'b00;
    @(negedge clk);
    check("rst_seq_issue", alu_enable, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst_mid");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_drop_resp_valid", resp_valid, 0);
      check("rst_drop_busy", busy, 0);
    end
    @(posedge clk); #1;
    model_last = 1'b1;
    exp_op = 4'd0; exp_in1 = 16'd0; exp_in2 = 16'd0;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      t.v    = 2'($urandom_range(1, 3));
      t.o0   = pick_op();  t.a0 = pick_word(); t.b0 = pick_word();
      t.o1   = pick_op();  t.a1 = pick_word(); t.b1 = pick_word();
      t.hold = int'($urandom_range(0, 3));
      t.w    = model_pick(t.v, model_last);
      t.e    = !((t.w ? t.o1 : t.o0) <= ALU_MUL);
      t.d    = t.e ? 16'h0000 : model_result(t.w ? t.o1 : t.o0,
                                             t.w ? t.a1 : t.a0,
                                             t.w ? t.b1 : t.b0);
      txn(t, waited);
      check("rand_grant_latency", waited, 0);
      model_last = t.w;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
